egress_port_unit: RTL
=====================

# egress_port_unit

Egress endpoint of the shared-cache switching fabric: takes one output lane of the sorting network, checks each cell's destination field against this port's ID, strips the routing header, and buffers the payload plus source port in a small FIFO. The buffer drains through a valid/ready handshake to the port's output logic. One instance sits on each network output lane.

## Interface
Parameters:
- DATA_WIDTH, 128, payload width in bits
- PORT_NUB, 16, number of switch ports; PW = $clog2(PORT_NUB)
- PORT_ID, 0, this instance's port number, 0..PORT_NUB-1
- FIFO_DEPTH, 8, payload buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cell_in  in  2*PW+DATA_WIDTH  fabric cell {rx_port, tx_port, data}; rx_port in the MSBs is the destination, tx_port is the source
- cell_valid  in  1  cell_in holds a real cell this cycle
- out_data  out  DATA_WIDTH  head-of-FIFO payload
- out_src  out  PW  head-of-FIFO source port (tx_port)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- misroute_cnt  out  16  cells received with rx_port ≠ PORT_ID
- drop_cnt  out  16  matching cells lost to a full FIFO

## Operation
- Stage 0 (capture): register cell_in and cell_valid unconditionally every cycle.
- Stage 1 (classify/write), on registered cell with valid=1:
  - rx_port == PORT_ID and (FIFO not full or a pop occurs this cycle): push {tx_port, data}.
  - rx_port == PORT_ID and FIFO full with no pop this cycle: discard; drop_cnt += 1.
  - rx_port ≠ PORT_ID: discard; misroute_cnt += 1.
- Pop occurs when out_valid && out_ready. out_ready with an empty FIFO has no effect.
- FIFO: circular buffer; write/read pointers carry PW_F+1 bits (PW_F = log2 FIFO_DEPTH). MSB is the wrap flag. Full = low bits equal and MSBs differ. Empty = pointers equal. fifo_level = wr_ptr - rd_ptr, computed modulo 2^(PW_F+1).
- Show-ahead output: out_data/out_src always reflect the head entry. They are undefined while out_valid=0.
- Counters saturate at 16'hFFFF and never wrap.
- No state machine beyond FIFO pointers. The block never back-pressures the fabric; loss is reported only through drop_cnt.

## Timing
- Reset values (rst=1 at a clock edge): out_valid=0, fifo_level=0, misroute_cnt=0, drop_cnt=0, both pointers 0, capture valid=0. out_data/out_src reset to 0.
- Reset mid-operation flushes all buffered cells. A cell presented in the same cycle rst is high is lost and is not counted.
- Latency: cell_valid at edge N → entry written at edge N+2 → out_valid=1 after edge N+2 if the FIFO was empty.
- Push and pop in the same cycle: level unchanged; allowed when full (the popped slot is reused) and when level=1 (out_valid stays 1 with the new head).
- Throughput: one cell accepted and one cell drained per cycle sustained.

## Configuration
- EGRESS_STATS_EN defined: misroute_cnt and drop_cnt are implemented as described.
- EGRESS_STATS_EN undefined: counter registers are not built; both outputs are tied to 16'd0. Filtering and drop behaviour are otherwise identical.

## Structure
- Shared package switch_pkg holds:
  - the port-width function/constant (PW)
  - the cell width (2*PW+DATA_WIDTH)
  - field offsets for rx_port, tx_port and data, also used by the network stages and the ingress packer
  - the 16-bit counter width constant
- One sub-module: egress_fifo. It is a parameterised show-ahead circular FIFO with push/pop/full/empty/level. The top level contains the capture register, classification and counters.

## Test plan
- Reset then idle: rst=1 two cycles, release → out_valid=0, fifo_level=0, both counters 0.
- PORT_ID=3: single cell {rx=3, tx=9, data=128'hA5…} at edge N, out_ready=1 → out_valid at N+2 with out_src=9 and data matching; level returns to 0 the cycle after the pop.
- Misroute: 5 cells with rx=4 to PORT_ID=3 → nothing enters the FIFO; misroute_cnt=5.
- Overflow: out_ready=0, 10 matching cells back-to-back, FIFO_DEPTH=8 → fifo_level=8, drop_cnt=2. Drain order is the first 8 cells in arrival order.
- Full with simultaneous push/pop: FIFO full, out_ready=1 while matching cells keep arriving → level stays 8, drop_cnt unchanged, output order preserved.
- Reset mid-burst: rst asserted with 4 entries buffered → next cycle out_valid=0, level=0, counters 0; the cell arriving during rst does not appear.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch-fabric definitions: port/cell widths, cell field offsets
// and statistics counter width. Used by the network stages, the ingress
// packer and the egress port unit.
package switch_pkg;

   // Width of every statistics counter in the fabric
   localparam int unsigned CNT_W = 16;

   // Bits needed to address one of port_nub ports (at least one bit)
   function automatic int unsigned port_width(input int unsigned port_nub);
      return (port_nub > 1) ? $clog2(port_nub) : 1;
   endfunction

   // Fabric cell layout, MSB to LSB: {rx_port, tx_port, data}
   function automatic int unsigned cell_width(input int unsigned port_nub,
                                              input int unsigned data_width);
      return 2 * port_width(port_nub) + data_width;
   endfunction

   localparam int unsigned DATA_LSB = 0;

   function automatic int unsigned tx_lsb(input int unsigned data_width);
      return data_width;
   endfunction

   function automatic int unsigned rx_lsb(input int unsigned port_nub,
                                          input int unsigned data_width);
      return data_width + port_width(port_nub);
   endfunction

endpackage

// File: rtl/egress_fifo.sv
// Show-ahead circular FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter; the head entry is
// presented combinationally on o_data (forced to zero while empty).
module egress_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = i_pop & ~o_empty;
   // A push into a full buffer is only legal when the head leaves this cycle
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Advance read/write pointers on pop/push
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Store the pushed entry at the write slot (storage needs no reset)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/egress_port_unit.sv
// Egress endpoint of one sorting-network output lane: captures the lane,
// keeps cells addressed to PORT_ID, strips the header and buffers
// {tx_port, data} for the port's valid/ready consumer.
// Optional statistics counters are built when EGRESS_STATS_EN is defined.
module egress_port_unit
   import switch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned PORT_NUB   = 16,
   parameter int unsigned PORT_ID    = 0,
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned PW = port_width(PORT_NUB),
   localparam int unsigned CW = cell_width(PORT_NUB, DATA_WIDTH),
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CW-1:0]         cell_in,
   input  logic                  cell_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [PW-1:0]         out_src,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LW-1:0]         fifo_level,
   output logic [CNT_W-1:0]      misroute_cnt,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam int unsigned TX_LSB = tx_lsb(DATA_WIDTH);
   localparam int unsigned RX_LSB = rx_lsb(PORT_NUB, DATA_WIDTH);

   logic [CW-1:0]            r_cell;
   logic                     r_valid;
   logic [PW-1:0]            w_rx;
   logic                     w_id_hit;
   logic                     w_match;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_full;
   logic                     w_empty;
   logic [PW+DATA_WIDTH-1:0] w_wr_entry;
   logic [PW+DATA_WIDTH-1:0] w_head;

   // Capture the lane every cycle; reset discards any cell in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cell  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_cell  <= cell_in;
         r_valid <= cell_valid;
      end
   end

   assign w_rx       = r_cell[RX_LSB +: PW];
   assign w_id_hit   = (w_rx == PW'(PORT_ID));
   assign w_match    = r_valid & w_id_hit;
   assign w_pop      = out_valid & out_ready;
   assign w_push     = w_match & (~w_full | w_pop);
   assign w_wr_entry = {r_cell[TX_LSB +: PW], r_cell[DATA_LSB +: DATA_WIDTH]};

   egress_fifo #(
      .WIDTH (PW + DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_wr_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign out_valid = ~w_empty;
   assign out_src   = w_head[DATA_WIDTH +: PW];
   assign out_data  = w_head[DATA_WIDTH-1:0];

`ifdef EGRESS_STATS_EN
   logic             w_misroute;
   logic             w_drop;
   logic [CNT_W-1:0] r_misroute_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   assign w_misroute = r_valid & ~w_id_hit;
   assign w_drop     = w_match & w_full & ~w_pop;

   // Saturating misroute/drop statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         r_misroute_cnt <= '0;
         r_drop_cnt     <= '0;
      end else begin
         if (w_misroute && (r_misroute_cnt != '1))
            r_misroute_cnt <= r_misroute_cnt + CNT_W'(1);
         if (w_drop && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
   end

   assign misroute_cnt = r_misroute_cnt;
   assign drop_cnt     = r_drop_cnt;
`else
   assign misroute_cnt = '0;
   assign drop_cnt     = '0;
`endif

endmodule
